tile_move_engine: RTL and testbench
===================================

TILE_MOVE_ENGINE -- requirements
Module: tile_move_engine

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  move request; sampled only in IDLE.
REQ-005 dir  input  2  move direction: 0 left, 1 right, 2 up, 3 down; captured with start.
REQ-006 tile_pos  output  4  tile index driven to the 4-from-64 tile selector.
REQ-007 tile_val  input  4  tile exponent returned combinationally by the selector for tile_pos in the same cycle.
REQ-008 busy  output  1  high while a move is in progress.
REQ-009 done  output  1  one-cycle pulse when board_out, moved and score_add are valid.
REQ-010 board_out  output  64  resulting board; tile p occupies bits [4p+3:4p], p = row*4+col.
REQ-011 moved  output  1  board_out differs from the input board.
REQ-012 score_add  output  20  sum of merged tile values for the move.

Function
REQ-013 Tile encoding SHALL be: 0 means empty; e in 1..15 means value 2^e.
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE after the 4th line write, and DONE->IDLE unconditionally.
REQ-015 Start in IDLE SHALL latch dir, clear the line counter, the tile counter k, moved and score_add, and set busy at that same edge (E0).
REQ-016 RUN SHALL process lines 0..3, each taking 4 read cycles (k=0..3, capturing tile_val into a 4-entry line buffer at each edge) followed by 1 write cycle.
REQ-017 The line index L SHALL map to tile_pos as follows, with k=0 at the destination edge: left L*4+k; right L*4+3-k; up k*4+L; down (3-k)*4+L.
REQ-018 The write cycle SHALL compact the non-zero tiles toward k=0 while preserving order.
REQ-019 The write cycle SHALL then merge equal adjacent tiles starting from k=0; each tile merges at most once.
REQ-020 A merged tile SHALL become e+1, and the vacated slots SHALL fill with 0.
REQ-021 Tiles with e=15 SHALL NOT merge.
REQ-022 Each merge SHALL add 2^(e+1), zero-extended to 20 bits, to score_add; the maximum is 8*2^15, so score_add never overflows.
REQ-023 The write cycle SHALL store the 4 result tiles into board_out at their mapped positions.
REQ-024 The write cycle SHALL OR (result line != captured line) into moved.
REQ-025 Latency: the 4th line write occurs at edge E20; done=1 and busy=0 during the cycle after E20, and state returns to IDLE at E21.
REQ-026 busy SHALL be high for exactly 20 cycles per move.
REQ-027 In IDLE and DONE, tile_pos SHALL be 0.
REQ-028 start while busy or in DONE SHALL be ignored; back-to-back start is accepted in the first IDLE cycle after done.
REQ-029 board_out, moved and score_add SHALL hold their values from done until the next accepted start; board_out keeps its last result until overwritten line by line.
REQ-030 Changes to dir while busy SHALL have no effect.
REQ-031 The upstream board SHALL be held stable while busy; the engine does not check this.

Reset
REQ-032 On rst_n=0, at any time including mid-move, the engine SHALL go to IDLE with busy=0, done=0, tile_pos=0, board_out=0, moved=0, score_add=0 and counters at 0.
REQ-033 The first start after rst_n rises SHALL behave identically to a start after a completed move.

Verification
REQ-034 Left, row0 = [1,1,2,2], other rows 0 (board=0x...2211) -> row0 becomes [2,3,0,0], board_out[15:0]=0x0032, score_add=12, moved=1, done at cycle 21 after start.
REQ-035 Left, row0 = [1,1,1,1] -> [2,2,0,0], score_add=8. Right, row0 = [0,2,0,2] -> [0,0,0,3], score_add=8.
REQ-036 Up, column 0 = [15,15,0,0] top to bottom -> unchanged, score_add=0, moved=0. Down, column 2 = [1,0,0,1] -> [0,0,0,2], moved=1.
REQ-037 Full board with no adjacent equal tiles and no empties -> board_out equals input, moved=0, score_add=0, busy high for exactly 20 cycles.
REQ-038 Assert rst_n=0 at cycle 10 of a move -> outputs zero immediately; a subsequent start completes a correct move. start pulsed while busy -> ignored, with exactly one done.

Source files
------------

// File: rtl/tile_move_if.sv
// rtl/tile_move_if.sv - move request, tile selector and result signals of the tile move engine
interface tile_move_if;
    logic        start;
    logic [1:0]  dir;
    logic [3:0]  tile_pos;
    logic [3:0]  tile_val;
    logic        busy;
    logic        done;
    logic [63:0] board_out;
    logic        moved;
    logic [19:0] score_add;

    modport master (
        output start, dir, tile_val,
        input  tile_pos, busy, done, board_out, moved, score_add
    );

    modport slave (
        input  start, dir, tile_val,
        output tile_pos, busy, done, board_out, moved, score_add
    );
endinterface

// File: rtl/tile_move_engine.sv
// rtl/tile_move_engine.sv - 2048-style slide/merge of a 4x4 board, one line per 5 cycles
module tile_move_engine (
    input  logic      clk,
    input  logic      rst_n,
    tile_move_if.slave mv
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      dir_q, dir_d;
    logic [1:0]      line_q, line_d;
    logic [2:0]      k_q, k_d;
    logic [3:0][3:0] line_buf_q, line_buf_d;
    logic [3:0]      tile_pos_q, tile_pos_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [63:0]     board_q, board_d;
    logic            moved_q, moved_d;
    logic [19:0]     score_q, score_d;

    logic [3:0][3:0] cmp;
    logic [3:0][3:0] res;
    logic [2:0]      n;
    logic [19:0]     gain;

    // k=0 is always the slot nearest the edge the tiles slide toward.
    function automatic logic [3:0] map_pos(input logic [1:0] d, input logic [1:0] l,
                                           input logic [1:0] k);
        case (d)
            2'd0:    return {l, k};
            2'd1:    return {l, ~k};
            2'd2:    return {k, l};
            default: return {~k, l};
        endcase
    endfunction

    function automatic logic can_merge(input logic [3:0] a, input logic [3:0] b);
        return (a != 4'd0) && (a == b) && (a != 4'd15);
    endfunction

    function automatic logic [19:0] merge_gain(input logic [3:0] e);
        return 20'd1 << ({1'b0, e} + 5'd1);
    endfunction

    // Compact then merge the captured line; with at most four tiles the merge
    // pattern is one of: (01)(23), (01)2 3, 0(12)3, 0 1(23), or none.
    always_comb begin
        cmp  = '0;
        n    = 3'd0;
        res  = '0;
        gain = 20'd0;
        for (int i = 0; i < 4; i++) begin
            if (line_buf_q[i] != 4'd0) begin
                cmp[n[1:0]] = line_buf_q[i];
                n = n + 3'd1;
            end
        end
        if (can_merge(cmp[0], cmp[1])) begin
            res[0] = cmp[0] + 4'd1;
            gain   = merge_gain(cmp[0]);
            if (can_merge(cmp[2], cmp[3])) begin
                res[1] = cmp[2] + 4'd1;
                gain   = gain + merge_gain(cmp[2]);
            end else begin
                res[1] = cmp[2];
                res[2] = cmp[3];
            end
        end else begin
            res[0] = cmp[0];
            if (can_merge(cmp[1], cmp[2])) begin
                res[1] = cmp[1] + 4'd1;
                res[2] = cmp[3];
                gain   = merge_gain(cmp[1]);
            end else begin
                res[1] = cmp[1];
                if (can_merge(cmp[2], cmp[3])) begin
                    res[2] = cmp[2] + 4'd1;
                    gain   = merge_gain(cmp[2]);
                end else begin
                    res[2] = cmp[2];
                    res[3] = cmp[3];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        line_d     = line_q;
        k_d        = k_q;
        line_buf_d = line_buf_q;
        tile_pos_d = tile_pos_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        board_d    = board_q;
        moved_d    = moved_q;
        score_d    = score_q;
        case (state_q)
            IDLE: begin
                if (mv.start) begin
                    state_d    = RUN;
                    dir_d      = mv.dir;
                    line_d     = 2'd0;
                    k_d        = 3'd0;
                    moved_d    = 1'b0;
                    score_d    = 20'd0;
                    busy_d     = 1'b1;
                    tile_pos_d = map_pos(mv.dir, 2'd0, 2'd0);
                end
            end
            RUN: begin
                if (k_q != 3'd4) begin
                    line_buf_d[k_q[1:0]] = mv.tile_val;
                    k_d        = k_q + 3'd1;
                    tile_pos_d = (k_q == 3'd3) ? 4'd0
                                               : map_pos(dir_q, line_q, k_q[1:0] + 2'd1);
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        board_d[{map_pos(dir_q, line_q, 2'(i)), 2'b00} +: 4] = res[i];
                    end
                    moved_d = moved_q | (res != line_buf_q);
                    score_d = score_q + gain;
                    k_d     = 3'd0;
                    if (line_q == 2'd3) begin
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        tile_pos_d = 4'd0;
                    end else begin
                        line_d     = line_q + 2'd1;
                        tile_pos_d = map_pos(dir_q, line_q + 2'd1, 2'd0);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dir_q      <= 2'd0;
            line_q     <= 2'd0;
            k_q        <= 3'd0;
            line_buf_q <= '0;
            tile_pos_q <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            board_q    <= 64'd0;
            moved_q    <= 1'b0;
            score_q    <= 20'd0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            line_q     <= line_d;
            k_q        <= k_d;
            line_buf_q <= line_buf_d;
            tile_pos_q <= tile_pos_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            board_q    <= board_d;
            moved_q    <= moved_d;
            score_q    <= score_d;
        end
    end

    assign mv.tile_pos  = tile_pos_q;
    assign mv.busy      = busy_q;
    assign mv.done      = done_q;
    assign mv.board_out = board_q;
    assign mv.moved     = moved_q;
    assign mv.score_add = score_q;
endmodule

// File: tb/tb_tile_move_engine.sv
// tb/tb_tile_move_engine.sv - directed and random moves checked against a queue-based move model
module tb_tile_move_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] board_in = 64'd0;
    int          checks = 0;
    int          errors = 0;

    tile_move_if bus ();

    tile_move_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mv    (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.tile_val = board_in[{bus.tile_pos, 2'b00} +: 4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input int d, input int l, input int k);
        int row, col;
        case (d)
            0:       begin row = l;     col = k;     end
            1:       begin row = l;     col = 3 - k; end
            2:       begin row = k;     col = l;     end
            default: begin row = 3 - k; col = l;     end
        endcase
        return row * 4 + col;
    endfunction

    task automatic model(input logic [63:0] b, input int d, output logic [63:0] r,
                         output logic mvd, output logic [19:0] sc);
        r  = b;
        sc = 20'd0;
        for (int l = 0; l < 4; l++) begin
            int q[$];
            int o[$];
            int i;
            for (int k = 0; k < 4; k++) begin
                int t;
                t = int'(b[pos_of(d, l, k) * 4 +: 4]);
                if (t != 0) q.push_back(t);
            end
            i = 0;
            while (i < q.size()) begin
                if (i + 1 < q.size() && q[i] == q[i + 1] && q[i] != 15) begin
                    o.push_back(q[i] + 1);
                    sc = sc + 20'(2 ** (q[i] + 1));
                    i += 2;
                end else begin
                    o.push_back(q[i]);
                    i += 1;
                end
            end
            while (o.size() < 4) o.push_back(0);
            for (int k = 0; k < 4; k++) r[pos_of(d, l, k) * 4 +: 4] = 4'(o[k]);
        end
        mvd = (r != b);
    endtask

    task automatic run_move(input logic [63:0] b, input logic [1:0] d, input bit poke);
        logic [63:0] eb;
        logic        em;
        logic [19:0] es;
        int          edges;
        int          busy_cnt;
        bit          got;
        model(b, int'(d), eb, em, es);
        board_in = b;
        @(posedge clk); #1;
        chk("idle_tile_pos", 64'(bus.tile_pos), 64'd0);
        bus.start = 1'b1;
        bus.dir   = d;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges    = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && edges < 40) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                got = 1'b1;
            end else begin
                bus.dir   = 2'($urandom);
                bus.start = (poke && edges == 7);
                @(posedge clk); #1;
                edges++;
            end
        end
        bus.start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        chk("done_latency", 64'(edges), 64'd20);
        chk("busy_cycles", 64'(busy_cnt), 64'd20);
        chk("board_out", bus.board_out, eb);
        chk("moved", 64'(bus.moved), 64'(em));
        chk("score_add", 64'(bus.score_add), 64'(es));
        @(posedge clk); #1;
        chk("done_single", 64'(bus.done), 64'd0);
        chk("busy_after", 64'(bus.busy), 64'd0);
        chk("hold_board", bus.board_out, eb);
        chk("hold_score", 64'(bus.score_add), 64'(es));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_pos"}, 64'(bus.tile_pos), 64'd0);
        chk({tag, "_board"}, bus.board_out, 64'd0);
        chk({tag, "_moved"}, 64'(bus.moved), 64'd0);
        chk({tag, "_score"}, 64'(bus.score_add), 64'd0);
    endtask

    initial begin
        logic [63:0] b;
        bus.start = 1'b0;
        bus.dir   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_move(64'h2211, 2'd0, 1'b0);
        chk("row0_1122_left", 64'(bus.board_out[15:0]), 64'h0032);
        chk("score_1122_left", 64'(bus.score_add), 64'd12);
        chk("moved_1122_left", 64'(bus.moved), 64'd1);

        run_move(64'h1111, 2'd0, 1'b0);
        chk("row0_1111_left", 64'(bus.board_out[15:0]), 64'h0022);
        chk("score_1111_left", 64'(bus.score_add), 64'd8);

        run_move(64'h2020, 2'd1, 1'b0);
        chk("row0_0202_right", 64'(bus.board_out[15:0]), 64'h3000);
        chk("score_0202_right", 64'(bus.score_add), 64'd8);

        run_move(64'h000F_000F, 2'd2, 1'b0);
        chk("e15_no_merge", bus.board_out, 64'h000F_000F);
        chk("e15_moved", 64'(bus.moved), 64'd0);
        chk("e15_score", 64'(bus.score_add), 64'd0);

        run_move(64'h0100_0000_0000_0100, 2'd3, 1'b0);
        chk("col2_down", bus.board_out, 64'h0200_0000_0000_0000);
        chk("col2_down_moved", 64'(bus.moved), 64'd1);

        b = 64'd0;
        for (int p = 0; p < 16; p++) b[p * 4 +: 4] = (((p / 4) + (p % 4)) % 2 != 0) ? 4'd2 : 4'd1;
        run_move(b, 2'($urandom), 1'b0);
        chk("full_unchanged", bus.board_out, b);
        chk("full_moved", 64'(bus.moved), 64'd0);

        for (int t = 0; t < 24; t++) begin
            b = 64'd0;
            for (int p = 0; p < 16; p++) begin
                if ($urandom_range(0, 9) == 0) b[p * 4 +: 4] = 4'd15;
                else b[p * 4 +: 4] = 4'($urandom_range(0, 3));
            end
            run_move(b, 2'($urandom), (t % 2) == 1);
        end

        board_in = 64'h1111_2222_0000_3300;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.dir   = 2'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midmove_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_move(64'h1111_2222_0000_3300, 2'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
